// File: rtl/amiga_kbd_tx_pkg.sv
// Shared constants, FSM encoding and line-byte helper for the Amiga keyboard transmitter.
package amiga_kbd_pkg;

    localparam logic [7:0] KBD_LOST_SYNC = 8'hF9;
    localparam logic [7:0] KBD_OVERFLOW  = 8'hFA;
    localparam logic [7:0] KBD_INIT      = 8'hFD;
    localparam logic [7:0] KBD_TERM      = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_WAIT_HS,
        ST_WAIT_REL,
        ST_SYNC_LO,
        ST_SYNC_HI
    } kbd_state_t;

    // Rotate left by one and invert: the byte as it appears on KDAT, MSB first.
    function automatic logic [7:0] kbd_line_byte(input logic [7:0] code);
        return ~{code[6:0], code[7]};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/amiga_kbd_tx.sv
// Amiga keyboard transmitter: event capture, FIFO, KDAT/KCLK serialiser with
// CIA handshake, power-up codes, overflow report and lost-sync recovery.
module amiga_kbd_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int T_PHASE    = 142,
    parameter int HS_TIMEOUT = 1014000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        kbd_mouse_level,
    input  logic [1:0]                  kbd_mouse_type,
    input  logic [7:0]                  kbd_mouse_data,
    input  logic                        kdat_i,
    output logic                        kdat_o,
    output logic                        kclk_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    import amiga_kbd_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(HS_TIMEOUT);

    logic          r_lvl_d, r_armed, r_push;
    logic [7:0]    r_din;
    logic          r_sync1, r_sync2;
    kbd_state_t    r_state, w_state_next;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift, r_code, r_failed;
    logic          r_lost, r_resend, r_cur_f9, r_pend_fa, r_overflow;
    logic [1:0]    r_pre;

    logic          w_fifo_full, w_fifo_empty, w_fifo_push, w_drop;
    logic [7:0]    w_fifo_dout;
    logic [CW-1:0] w_fifo_count;
    logic          w_pop, w_load, w_sel_lost, w_sel_resend, w_sel_fa, w_sel_pre;
    logic [7:0]    w_load_code;
    logic          w_kdat, w_kclk, w_timer_clr, w_timeout, w_bit_inc, w_phase_done;

    // r_armed suppresses a spurious event while the level history loads after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lvl_d <= 1'b0;
            r_armed <= 1'b0;
            r_push  <= 1'b0;
            r_din   <= '0;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_lvl_d <= kbd_mouse_level;
            r_armed <= 1'b1;
            r_push  <= r_armed && (kbd_mouse_level != r_lvl_d) && (kbd_mouse_type == 2'd2);
            r_din   <= kbd_mouse_data;
            r_sync1 <= kdat_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_drop      = r_push && w_fifo_full && !w_pop;
    assign w_fifo_push = r_push && !w_drop;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_fifo_push),
        .pop     (w_pop),
        .din     (r_din),
        .dout    (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    assign w_phase_done = (r_timer == TW'(T_PHASE - 1));

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_sel_lost   = 1'b0;
        w_sel_resend = 1'b0;
        w_sel_fa     = 1'b0;
        w_sel_pre    = 1'b0;
        w_load       = 1'b0;
        w_load_code  = w_fifo_dout;
        w_kdat       = 1'b1;
        w_kclk       = 1'b1;
        w_timer_clr  = 1'b0;
        w_timeout    = 1'b0;
        w_bit_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_clr = 1'b1;
                if (r_lost) begin
                    w_sel_lost  = 1'b1;
                    w_load_code = KBD_LOST_SYNC;
                end else if (r_resend) begin
                    w_sel_resend = 1'b1;
                    w_load_code  = r_failed;
                end else if (r_pend_fa) begin
                    w_sel_fa    = 1'b1;
                    w_load_code = KBD_OVERFLOW;
                end else if (r_pre != 2'd0) begin
                    w_sel_pre   = 1'b1;
                    w_load_code = (r_pre == 2'd2) ? KBD_INIT : KBD_TERM;
                end else if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                end
                w_load = w_sel_lost | w_sel_resend | w_sel_fa | w_sel_pre | w_pop;
                if (w_load) w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_kdat = r_shift[7];
                if (w_phase_done) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_CLK_LO;
                end
            end
            ST_CLK_LO: begin
                w_kdat = r_shift[7];
                w_kclk = 1'b0;
                if (w_phase_done) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                w_kdat = r_shift[7];
                if (w_phase_done) begin
                    w_timer_clr = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_next = ST_WAIT_HS;
                    end else begin
                        w_bit_inc    = 1'b1;
                        w_state_next = ST_SETUP;
                    end
                end
            end
            ST_WAIT_HS: begin
                // The synchroniser still carries our own last low bit for two cycles.
                if (!r_sync2 && (r_timer >= TW'(2))) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_WAIT_REL;
                end else if (r_timer == TW'(HS_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_SYNC_LO;
                end
            end
            ST_WAIT_REL: begin
                w_timer_clr = 1'b1;
                if (r_sync2) w_state_next = ST_IDLE;
            end
            ST_SYNC_LO: begin
                w_kdat = 1'b0;
                w_kclk = 1'b0;
                if (w_phase_done) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_SYNC_HI;
                end
            end
            ST_SYNC_HI: begin
                w_kdat = 1'b0;
                if (w_phase_done) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_WAIT_HS;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_bit      <= '0;
            r_shift    <= 8'hFF;
            r_code     <= '0;
            r_failed   <= '0;
            r_lost     <= 1'b0;
            r_resend   <= 1'b0;
            r_cur_f9   <= 1'b0;
            r_pend_fa  <= 1'b0;
            r_overflow <= 1'b0;
            r_pre      <= 2'd2;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_clr ? '0 : r_timer + TW'(1);
            if (w_load) begin
                r_shift  <= kbd_line_byte(w_load_code);
                r_code   <= w_load_code;
                r_bit    <= '0;
                r_cur_f9 <= w_sel_lost;
            end else if (w_bit_inc) begin
                r_shift <= {r_shift[6:0], 1'b1};
                r_bit   <= r_bit + 3'd1;
            end
            // A failed 0xF9 keeps the original code queued for retransmission.
            if (w_timeout) begin
                r_lost <= 1'b1;
                if (!r_cur_f9) r_failed <= r_code;
            end else if (w_sel_lost) begin
                r_lost   <= 1'b0;
                r_resend <= 1'b1;
            end else if (w_sel_resend) begin
                r_resend <= 1'b0;
            end
            if (w_drop) begin
                r_pend_fa  <= 1'b1;
                r_overflow <= 1'b1;
            end else if (w_sel_fa) begin
                r_pend_fa <= 1'b0;
            end
            if (w_sel_pre) r_pre <= r_pre - 2'd1;
        end
    end

    assign kdat_o     = w_kdat;
    assign kclk_o     = w_kclk;
    assign fifo_count = w_fifo_count + CW'(r_pre);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_amiga_kbd_tx.sv
// Directed/randomised bench for amiga_kbd_tx with a line monitor and CIA handshake model.
module tb_amiga_kbd_tx;

    localparam int TP    = 4;
    localparam int HST   = 400;
    localparam int DEPTH = 8;
    localparam int HSW   = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lvl = 1'b0;
    logic [1:0] typ = 2'd0;
    logic [7:0] dat = 8'd0;
    logic       cia_dat = 1'b1;
    logic       kdat_o, kclk_o, overflow;
    logic [3:0] fifo_count;
    logic       kdat_i;

    assign kdat_i = kdat_o & cia_dat;

    always #5 clk = ~clk;

    amiga_kbd_tx #(
        .FIFO_DEPTH (DEPTH),
        .T_PHASE    (TP),
        .HS_TIMEOUT (HST)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .kbd_mouse_level (lvl),
        .kbd_mouse_type  (typ),
        .kbd_mouse_data  (dat),
        .kdat_i          (kdat_i),
        .kdat_o          (kdat_o),
        .kclk_o          (kclk_o),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rxq[$];
    logic [7:0] rawq[$];
    logic [7:0] last_raw;
    int         fall_count = 0;
    int         sync_count = 0;
    bit         hs_enable = 1'b1;
    int         hs_delay = 20;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic evt(input logic [1:0] t, input logic [7:0] d);
        typ = t;
        dat = d;
        lvl = ~lvl;
        $display("event type=%0d data=%02h", t, d);
    endtask

    task automatic expect_code(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        for (int k = 0; k < 3000 && rxq.size() == 0; k++) @(negedge clk);
        if (rxq.size() == 0) begin
            check({tag, "_timeout"}, rxq.size(), 1);
        end else begin
            got      = rxq.pop_front();
            last_raw = rawq.pop_front();
            $display("rx %s code=%02h expected=%02h", tag, got, exp);
            check(tag, got, exp);
        end
    endtask

    // Line monitor and CIA model: decode bytes at KCLK rises, acknowledge after hs_delay.
    initial begin
        bit         prev_kclk = 1'b1;
        bit         low_bit = 1'b1;
        bit         wait_hs = 1'b0;
        bit         req = 1'b0;
        int         low_len = 0;
        int         nbits = 0;
        int         cnt = 0;
        int         cia_low = 0;
        logic [7:0] raw = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_kclk = 1'b1;
                wait_hs   = 1'b0;
                req       = 1'b0;
                nbits     = 0;
                low_len   = 0;
                cia_low   = 0;
                cia_dat   = 1'b1;
            end else begin
                if (cia_low > 0) begin
                    cia_low--;
                    if (cia_low == 0) cia_dat = 1'b1;
                end
                if (prev_kclk && !kclk_o) begin
                    low_len = 1;
                    low_bit = kdat_o;
                    fall_count++;
                end else if (!kclk_o) begin
                    low_len++;
                end
                if (!prev_kclk && kclk_o) begin
                    check("kclk_low_len", low_len, TP);
                    if (wait_hs) begin
                        sync_count++;
                        check("sync_bit_kdat", {31'd0, low_bit}, 0);
                        req = 1'b1;
                        cnt = 0;
                    end else begin
                        raw = {raw[6:0], low_bit};
                        nbits++;
                        if (nbits == 8) begin
                            rawq.push_back(raw);
                            rxq.push_back({~raw[0], ~raw[7:1]});
                            nbits   = 0;
                            wait_hs = 1'b1;
                            req     = 1'b1;
                            cnt     = 0;
                        end
                    end
                end
                prev_kclk = kclk_o;
                if (req) begin
                    cnt++;
                    if (hs_enable && cnt == hs_delay) begin
                        cia_dat = 1'b0;
                        cia_low = HSW;
                        req     = 1'b0;
                        wait_hs = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        logic [7:0] a;
        logic [7:0] q[$];
        int         fc;
        int         sc;
        bit         dropped;

        repeat (3) @(posedge clk);
        #1;
        check("rst_kdat", kdat_o, 1);
        check("rst_kclk", kclk_o, 1);
        check("rst_overflow", overflow, 0);
        check("rst_count", fifo_count, 2);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("count_after_release", fifo_count, 2);
        expect_code("init_fd", 8'hFD);
        expect_code("init_fe", 8'hFE);
        repeat (60) @(posedge clk);
        #1;
        check("count_after_init", fifo_count, 0);

        // Latency from toggle to first driven bit, then line pattern of 0x45.
        @(posedge clk);
        #1;
        evt(2'd2, 8'h45);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("latency_cycle2_kdat", kdat_o, 1);
        @(posedge clk);
        #1;
        check("latency_cycle3_kdat", kdat_o, 0);
        expect_code("key45", 8'h45);
        check("key45_line", last_raw, 8'h75);
        repeat (60) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            c = 8'($urandom);
            @(posedge clk);
            #1;
            evt(2'd2, c);
            expect_code("rand_key", c);
            repeat (60) @(posedge clk);
        end

        // Non-keyboard event types must not reach the line.
        fc = fall_count;
        for (int t = 0; t < 4; t++) begin
            if (t != 2) begin
                @(posedge clk);
                #1;
                evt(2'(t), 8'($urandom));
                repeat (5) @(posedge clk);
            end
        end
        repeat (200) @(posedge clk);
        #1;
        check("mouse_no_kclk", fall_count, fc);
        check("mouse_no_push", fifo_count, 0);
        check("no_overflow_yet", overflow, 0);

        // Overflow: one code in flight, then more pushes than the FIFO holds.
        hs_delay = 300;
        a = 8'($urandom);
        fc = fall_count;
        @(posedge clk);
        #1;
        evt(2'd2, a);
        for (int k = 0; k < 500 && fall_count == fc; k++) @(posedge clk);
        check("ovf_first_started", {31'd0, fall_count != fc}, 1);
        q.delete();
        dropped = 1'b0;
        for (int i = 0; i < 9; i++) begin
            c = 8'($urandom);
            repeat (4) @(posedge clk);
            #1;
            evt(2'd2, c);
            if (q.size() < DEPTH) q.push_back(c);
            else dropped = 1'b1;
        end
        repeat (5) @(posedge clk);
        #1;
        check("ovf_count_full", fifo_count, q.size());
        check("ovf_flag", overflow, dropped);
        expect_code("ovf_first", a);
        for (int k = 0; k < 2000 && cia_dat; k++) @(posedge clk);
        hs_delay = 20;
        if (dropped) expect_code("ovf_fa", 8'hFA);
        while (q.size() > 0) expect_code("ovf_queued", q.pop_front());
        repeat (60) @(posedge clk);
        #1;
        check("ovf_sticky", overflow, 1);
        check("ovf_drained", fifo_count, 0);

        // Lost sync: withhold the handshake, then acknowledge a sync bit.
        hs_enable = 1'b0;
        c = 8'($urandom);
        @(posedge clk);
        #1;
        evt(2'd2, c);
        expect_code("sync_first", c);
        sc = sync_count;
        for (int k = 0; k < 3000 && sync_count < sc + 2; k++) @(posedge clk);
        check("sync_pulses", {31'd0, sync_count >= sc + 2}, 1);
        hs_enable = 1'b1;
        expect_code("sync_f9", 8'hF9);
        expect_code("sync_retx", c);
        repeat (60) @(posedge clk);

        // Reset during a KCLK low phase.
        c = 8'($urandom) | 8'h40;
        @(posedge clk);
        #1;
        evt(2'd2, c);
        for (int k = 0; k < 500 && kclk_o; k++) @(posedge clk);
        check("midbit_reached_low", kclk_o, 0);
        #2;
        check("midbit_kdat_low", kdat_o, 0);
        reset_n = 1'b0;
        #1;
        check("midbit_rst_kclk", kclk_o, 1);
        check("midbit_rst_kdat", kdat_o, 1);
        repeat (3) @(posedge clk);
        #1;
        check("midbit_rst_overflow", overflow, 0);
        check("midbit_rst_count", fifo_count, 2);
        @(negedge clk);
        reset_n = 1'b1;
        check("midbit_no_partial", rxq.size(), 0);
        expect_code("reinit_fd", 8'hFD);
        expect_code("reinit_fe", 8'hFE);
        repeat (60) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
